// File: rtl/burst_serialize_if.sv
// Handshake bundle between a vector producer, burst_serialize and the downstream burst consumer.
// res_lst exists only when BURST_SERIALIZE_LAST_EN is defined.
interface burst_serialize_if #(
    parameter int ARGW = 32,
    parameter int LEN  = 4
);
    logic                  arg_stb;
    logic [LEN*ARGW-1:0]   arg_dat;
    logic                  arg_rdy;
    logic                  res_stb;
    logic [ARGW-1:0]       res_dat;
    logic                  res_rdy;
`ifdef BURST_SERIALIZE_LAST_EN
    logic                  res_lst;
`endif

    modport slave (
        input  arg_stb,
        input  arg_dat,
        input  res_rdy,
        output arg_rdy,
        output res_stb,
`ifdef BURST_SERIALIZE_LAST_EN
        output res_lst,
`endif
        output res_dat
    );

    modport master (
        output arg_stb,
        output arg_dat,
        output res_rdy,
        input  arg_rdy,
        input  res_stb,
`ifdef BURST_SERIALIZE_LAST_EN
        input  res_lst,
`endif
        input  res_dat
    );
endinterface

// File: rtl/burst_serialize.sv
// Serialises one LEN-element word into a contiguous res_stb burst followed by a forced idle gap.
// Optional end-of-burst flag res_lst is enabled by defining BURST_SERIALIZE_LAST_EN.
module burst_serialize #(
    parameter int ARGW = 32,
    parameter int LEN  = 4,
    parameter int GAP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    burst_serialize_if.slave   bus
);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [LEN*ARGW-1:0]   data_q, data_d;
    logic                  stb_q, stb_d;
`ifdef BURST_SERIALIZE_LAST_EN
    logic                  lst_q, lst_d;
`endif

    // Latched word is shifted down so the current element always sits in the low slice.
    assign bus.res_dat = data_q[ARGW-1:0];
    assign bus.res_stb = stb_q;
    assign bus.arg_rdy = rst & (state_q == IDLE);
`ifdef BURST_SERIALIZE_LAST_EN
    assign bus.res_lst = lst_q;
`endif

    // Next-state and next-output logic for the IDLE/SEND/HOLD sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        data_d  = data_q;
        stb_d   = stb_q;
        case (state_q)
            IDLE: begin
                stb_d = 1'b0;
                if (bus.arg_stb) begin
                    data_d  = bus.arg_dat;
                    idx_d   = '0;
                    stb_d   = 1'b1;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                stb_d = 1'b1;
                if (bus.res_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        gap_d   = GAP_LOAD;
                        stb_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        idx_d  = idx_q + IW'(1);
                        data_d = data_q >> ARGW;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            HOLD: begin
                stb_d = 1'b0;
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef BURST_SERIALIZE_LAST_EN
    // End-of-burst flag follows the registered strobe and the index it will present.
    always_comb begin
        lst_d = stb_d & (idx_d == LAST_IDX);
    end
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
`ifdef BURST_SERIALIZE_LAST_EN
            lst_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
`ifdef BURST_SERIALIZE_LAST_EN
            lst_q   <= lst_d;
`endif
        end
    end
endmodule

// File: doc/burst_serialize.md
Name: burst_serialize

Overview:
- Transmit side of the burst stream protocol consumed by `accumulate`.
- Accepts one wide word of LEN packed elements on a strobe/ready input.
- Emits the elements one per beat as a contiguous `res_stb` burst, then holds `res_stb` low for at least GAP cycles so a downstream burst consumer detects end-of-burst.
- Sits between vector producers (weight/activation buffers) and reduction blocks.

Parameters:
- ARGW, 32, element width in bits.
- LEN, 4, elements per input word (>= 1).
- GAP, 1, idle cycles forced after each burst (>= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low.
- arg_stb  input  1  input word valid.
- arg_dat  input  LEN*ARGW  packed elements; element k = arg_dat[k*ARGW +: ARGW].
- arg_rdy  output  1  block can accept a word.
- res_stb  output  1  output element valid.
- res_dat  output  ARGW  current element.
- res_rdy  input  1  downstream accepts element.

Behaviour:
- Reset: rst low at a clock edge puts the block in IDLE.
  - Reset values: res_stb=0, res_dat=0, element index=0, gap counter=0.
  - arg_rdy is forced 0 while rst is low.
- FSM states: IDLE, SEND, HOLD.
- IDLE:
  - arg_rdy=1, res_stb=0.
  - On arg_stb & arg_rdy: latch arg_dat into the internal register, set index=0, go to SEND.
  - res_stb=1 with element 0 on the next cycle (latency 1).
- SEND:
  - arg_rdy=0, res_stb=1, res_dat = element[index], taken from the latched copy.
  - Later changes on arg_dat have no effect.
  - On res_rdy & index<LEN-1: index+1.
  - On res_rdy & index==LEN-1: go to HOLD, load gap counter with GAP-1, res_stb=0 next cycle.
  - res_rdy low: res_stb and res_dat hold unchanged for any number of cycles.
  - res_stb never drops mid-burst.
- HOLD:
  - res_stb=0, arg_rdy=0.
  - Counter decrements each cycle; at 0, go to IDLE.
  - Total res_stb-low cycles after the last accepted element = GAP + 1: GAP in HOLD plus one in IDLE before the next word's first beat.
- Throughput with res_rdy tied high: one word every LEN+GAP+1 cycles.
- LEN=1: single-beat burst, then HOLD.
- Width rules:
  - Index width = max(1, clog2(LEN)).
  - Gap counter width = max(1, clog2(GAP)).
  - No arithmetic on data; elements pass bit-exact.
- Elements go out least-significant slice first.
- Reset mid-burst: burst aborted, latched word discarded, res_stb=0 from the next edge, no trailing HOLD.
- arg_stb asserted in SEND/HOLD: ignored, word not consumed; upstream holds it.
- res_dat is a don't-care while res_stb=0, except for the reset value.

Optional Feature:
- Macro: BURST_SERIALIZE_LAST_EN.
- Defined:
  - Adds output res_lst (1 bit), high exactly while res_stb=1 and index==LEN-1, else 0.
  - Reset value 0.
  - Downstream may use it instead of the gap; GAP still enforced.
- Undefined: port res_lst absent; behaviour otherwise identical.

Test Plan:
- ARGW=8, LEN=4, GAP=1, res_rdy=1; arg_dat=32'h04030201 accepted at cycle T.
  - res_stb=1 at T+1..T+4 with res_dat 01,02,03,04.
  - res_stb=0 at T+5 and T+6; arg_rdy=1 at T+6.
- Same word, res_rdy low for 3 cycles while element 02 is presented: res_stb stays 1, res_dat=02 held; sequence completes 01,02,03,04 with no gap inside the burst.
- Chained into accumulate (ARGW=8, RESW=16): words 32'h04030201 then 32'hFFFFFFFF back-to-back → accumulate results 16'd10 then 16'hFFFC (-4).
- rst driven low during element 03 for one cycle:
  - res_stb=0 next cycle.
  - After release, arg_rdy=1 and a new word 32'h0A0B0C0D emits 0D,0C,0B,0A.
- LEN=1, GAP=3: arg_dat=8'h55 → one beat 55, then res_stb low 4 cycles before the next word's beat; arg_stb held high throughout, accepted only when arg_rdy=1.
- BURST_SERIALIZE_LAST_EN defined, LEN=4: res_lst=1 only on the beat carrying 04; res_lst=0 under reset and in HOLD.
